dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters: the processor core's load/store path and a host port used to preload and read back data.
- Sits between the core datapath, the host harness and the data memory.
- Arbitrates once per cycle, routes the memory's one-cycle-latency read data back to the winner, and raises a core stall when the core loses.
- Keeps a starvation counter for the host and a saturating count of core stall cycles.

Parameters:
- AW, 8, address width (256-byte data memory).
- DW, 8, data width.
- MAX_WAIT, 4, consecutive denied host cycles after which the host is force-granted (range 1..15).
- CTW, 16, width of the core stall-cycle counter.

Ports:
- CLK  input  1  clock, posedge only.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- core_req  input  1  core requests a memory access this cycle.
- core_we  input  1  1 = write, 0 = read.
- core_addr  input  AW  core address.
- core_wdata  input  DW  core write data.
- core_gnt  output  1  core access is issued to memory this cycle.
- core_stall  output  1  core_req && !core_gnt.
- core_rvalid  output  1  core read data is valid this cycle.
- core_rdata  output  DW  read data to the core.
- host_req, host_we, host_addr, host_wdata  input  1/1/AW/DW  host equivalents of the core request signals.
- host_lock  input  1  keeps the host grant across consecutive cycles (burst).
- host_gnt, host_rvalid, host_rdata  output  1/1/DW  host equivalents of the core response signals.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid the cycle after the read is issued.
- stall_ct  output  CTW  saturating count of core stall cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear: wait_cnt=0, last_host=0, rv_pipe=none, stall_ct=0.
  - While reset=0, all grant, rvalid, stall and mem_en/mem_we outputs are forced to 0 regardless of requests.
- Arbitration is combinational from the current inputs plus registered state. At most one grant per cycle. host_gnt=1 when host_req=1 and any of:
  - core_req=0;
  - wait_cnt==MAX_WAIT;
  - host_lock=1 and last_host=1.
  Otherwise core_gnt=core_req. Default priority is to the core.
- Memory mux:
  - Winner's we/addr/wdata drive mem_*.
  - mem_en = core_gnt|host_gnt.
  - mem_we = winner's we && mem_en.
  - With no grant, mem_addr/mem_wdata=0.
- Read return:
  - A granted read registers an owner tag (NONE/CORE/HOST).
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata; the non-owner's rdata=0.
  - Writes produce no rvalid.
  - Back-to-back reads by either owner must return in order, one per cycle.
- wait_cnt (4 bits):
  - On each posedge: if host_req && !host_gnt, increment, saturating at MAX_WAIT.
  - Else clear to 0; a host grant or host_req=0 clears it.
- last_host: registered host_gnt. A lock burst ends when host_lock or host_req drops; the core then wins the next contested cycle.
- Forced grant: after a MAX_WAIT-forced host grant with host_lock=0, the next contested cycle goes to the core (wait_cnt is 0 again).
- stall_ct: +1 each cycle core_stall=1, saturating at 2^CTW-1. Not cleared except by reset.
- Reset mid-operation: a pending rvalid is dropped and no rvalid appears after reset release. The first cycle after release arbitrates from cleared state.
- Simultaneous write by host and read by core to the same address: only the winner's access occurs. The loser retries; the arbiter never merges accesses.
- Implementation: 120-400 lines; registers are wait_cnt, last_host, the rvalid tag pipe and stall_ct.

Test Plan:
- Core-only traffic: core read addr 0x10, memory returns 0xA5 → core_gnt=1 in cycle N; core_rvalid=1 with core_rdata=0xA5 in N+1; host outputs 0; stall_ct stays 0.
- Continuous contention, MAX_WAIT=4, host_lock=0, both req held 10 cycles → grants C,C,C,C,H,C,C,C,C,H; core_stall high in cycles 5 and 10; stall_ct=2.
- Host lock burst: host_lock=1, host writes 0x00..0x03 while core_req=1 → first host grant after 4 core cycles, then 4 consecutive host grants; core_gnt resumes the cycle after host_lock drops.
- Interleaved reads: core read in N, host read in N+1 (forced) → core_rvalid in N+1, host_rvalid in N+2, each carrying that cycle's mem_rdata; no cross-delivery.
- Async reset pulse: assert reset=0 mid-cycle after a granted read → rvalid never asserted, all grants 0 during reset, stall_ct=0, wait_cnt restarts from 0 after release.
- Saturation: CTW=4, core starved 20 stall cycles by host lock → stall_ct sticks at 15.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Core, host and memory-side signals of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          host_req;
  logic          host_we;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Core/host arbiter for a single-port data memory with host
//               starvation guard, lock bursts and a core stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4,
  parameter int CTW      = 16
) (
  input  wire logic           CLK,
  input  wire logic           reset,
  dmem_arbiter_if.slave       bus,
  output logic [CTW-1:0]      stall_ct
);

  typedef enum logic [1:0] {
    RV_NONE = 2'd0,
    RV_CORE = 2'd1,
    RV_HOST = 2'd2
  } rv_tag_e;

  localparam logic [3:0]     WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [CTW-1:0] CT_MAX   = '1;

  rv_tag_e        rv_q,        rv_d;
  logic [3:0]     wait_cnt_q,  wait_cnt_d;
  logic           last_host_q, last_host_d;
  logic [CTW-1:0] stall_ct_q,  stall_ct_d;

  logic host_win;
  logic core_gnt;
  logic host_gnt;
  logic core_stall;
  logic core_rvalid;
  logic host_rvalid;

  // Core has default priority; host wins when uncontested, starved or locked.
  always_comb begin
    host_win = bus.host_req &&
               (!bus.core_req ||
                (wait_cnt_q == WAIT_MAX) ||
                (bus.host_lock && last_host_q));
    host_gnt    = reset && host_win;
    core_gnt    = reset && bus.core_req && !host_win;
    core_stall  = reset && bus.core_req && !core_gnt;
    core_rvalid = reset && (rv_q == RV_CORE);
    host_rvalid = reset && (rv_q == RV_HOST);
  end

  always_comb begin
    bus.mem_en    = core_gnt || host_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (host_gnt) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else if (core_gnt) begin
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end
  end

  always_comb begin
    bus.core_gnt    = core_gnt;
    bus.core_stall  = core_stall;
    bus.core_rvalid = core_rvalid;
    bus.core_rdata  = core_rvalid ? bus.mem_rdata : '0;
    bus.host_gnt    = host_gnt;
    bus.host_rvalid = host_rvalid;
    bus.host_rdata  = host_rvalid ? bus.mem_rdata : '0;
    stall_ct        = stall_ct_q;
  end

  always_comb begin
    rv_d = RV_NONE;
    if (host_gnt && !bus.host_we) begin
      rv_d = RV_HOST;
    end else if (core_gnt && !bus.core_we) begin
      rv_d = RV_CORE;
    end

    wait_cnt_d = 4'd0;
    if (bus.host_req && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 4'd1;
    end

    last_host_d = host_gnt;

    stall_ct_d = stall_ct_q;
    if (core_stall && (stall_ct_q != CT_MAX)) begin
      stall_ct_d = stall_ct_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rv_q        <= RV_NONE;
      wait_cnt_q  <= 4'd0;
      last_host_q <= 1'b0;
      stall_ct_q  <= '0;
    end else begin
      rv_q        <= rv_d;
      wait_cnt_q  <= wait_cnt_d;
      last_host_q <= last_host_d;
      stall_ct_q  <= stall_ct_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed vector bench for dmem_arbiter with a 256-byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] stall_ct;
  logic [7:0] mem [256];
  logic [7:0] rdata_q;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus();

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4), .CTW(4)) dut (
    .CLK      (clk),
    .reset    (rst_n),
    .bus      (bus.slave),
    .stall_ct (stall_ct)
  );

  // Synchronous memory: preload ~addr (0xA5 at 0x10) during reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(~i);
      mem[16]  <= 8'hA5;
      rdata_q  <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  typedef struct {
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       hreq, hwe, hlk;
    logic [7:0] haddr, hwd;
    logic       cg, hg, cs, crv;
    logic [7:0] crd;
    logic       hrv;
    logic [7:0] hrd;
    logic [3:0] sct;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic creq, cwe, input logic [7:0] caddr, cwd,
    input logic hreq, hwe, hlk, input logic [7:0] haddr, hwd,
    input logic cg, hg, cs, crv, input logic [7:0] crd,
    input logic hrv, input logic [7:0] hrd, input logic [3:0] sct);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.hlk = hlk; v.haddr = haddr; v.hwd = hwd;
    v.cg = cg; v.hg = hg; v.cs = cs; v.crv = crv; v.crd = crd;
    v.hrv = hrv; v.hrd = hrd; v.sct = sct;
    return v;
  endfunction

  task automatic drive(input logic creq, cwe, input logic [7:0] caddr, cwd,
                       input logic hreq, hwe, hlk, input logic [7:0] haddr, hwd);
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cwd;
    bus.host_req   = hreq;
    bus.host_we    = hwe;
    bus.host_lock  = hlk;
    bus.host_addr  = haddr;
    bus.host_wdata = hwd;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int row;
    logic [3:0] exp_ct;

    // A: core-only read of 0x10
    tbl.push_back(mk(1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00,0,8'h00,4'd0));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'hA5,0,8'h00,4'd0));
    // B: continuous contention, host writes 0x11 to 0x80
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 1,0,0,0,8'h00,0,8'h00,4'd0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 1,0,0,1,8'hDF,0,8'h00,4'd0));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 0,1,1,1,8'hDF,0,8'h00,4'd0));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 1,0,0,0,8'h00,0,8'h00,4'd1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 1,0,0,1,8'hDF,0,8'h00,4'd1));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,0,8'h80,8'h11, 0,1,1,1,8'hDF,0,8'h00,4'd1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00,0,8'h00,4'd2));
    // C: host lock burst writing 0x00..0x03
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h00,8'h30, 1,0,0,0,8'h00,0,8'h00,4'd2));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h00,8'h30, 1,0,0,1,8'hDF,0,8'h00,4'd2));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h00,8'h30, 0,1,1,1,8'hDF,0,8'h00,4'd2));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h01,8'h31, 0,1,1,0,8'h00,0,8'h00,4'd3));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h02,8'h32, 0,1,1,0,8'h00,0,8'h00,4'd4));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,1,1,8'h03,8'h33, 0,1,1,0,8'h00,0,8'h00,4'd5));
    tbl.push_back(mk(1,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00,0,8'h00,4'd6));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'hDF,0,8'h00,4'd6));
    // D: interleaved reads, host forced in the cycle after a core read
    tbl.push_back(mk(1,0,8'h40,8'h00, 1,0,0,8'h41,8'h00, 1,0,0,0,8'h00,0,8'h00,4'd6));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h40,8'h00, 1,0,0,8'h41,8'h00, 1,0,0,1,8'hBF,0,8'h00,4'd6));
    tbl.push_back(mk(1,0,8'h40,8'h00, 1,0,0,8'h41,8'h00, 0,1,1,1,8'hBF,0,8'h00,4'd6));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00,1,8'hBE,4'd7));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 0,1,0,0,8'h00,0,8'h00,4'd7));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,0,0,8'h80,8'h00, 0,1,0,0,8'h00,1,8'hA5,4'd7));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,8'h00,1,8'h11,4'd7));
    // E: same-address host write vs core read; core wins, host retries alone
    tbl.push_back(mk(1,0,8'h50,8'h00, 1,1,0,8'h50,8'h77, 1,0,0,0,8'h00,0,8'h00,4'd7));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,0,8'h50,8'h77, 0,1,0,1,8'hAF,0,8'h00,4'd7));
    tbl.push_back(mk(1,0,8'h50,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0,8'h00,0,8'h00,4'd7));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1,8'h77,0,8'h00,4'd7));

    // Reset with both requesters active
    rst_n = 1'b0;
    drive(1,0,8'h10,8'h00, 1,0,0,8'h20,8'h00);
    repeat (3) @(posedge clk);
    #3;
    chk("rst core_gnt", 16'(bus.core_gnt), 16'd0);
    chk("rst host_gnt", 16'(bus.host_gnt), 16'd0);
    chk("rst core_stall", 16'(bus.core_stall), 16'd0);
    chk("rst mem_en", 16'(bus.mem_en), 16'd0);
    chk("rst core_rvalid", 16'(bus.core_rvalid), 16'd0);
    chk("rst stall_ct", 16'(stall_ct), 16'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    next_cycle();

    row = 0;
    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.creq, v.cwe, v.caddr, v.cwd, v.hreq, v.hwe, v.hlk, v.haddr, v.hwd);
      #3;
      chk($sformatf("row%0d core_gnt", row),    16'(bus.core_gnt),    16'(v.cg));
      chk($sformatf("row%0d host_gnt", row),    16'(bus.host_gnt),    16'(v.hg));
      chk($sformatf("row%0d core_stall", row),  16'(bus.core_stall),  16'(v.cs));
      chk($sformatf("row%0d core_rvalid", row), 16'(bus.core_rvalid), 16'(v.crv));
      chk($sformatf("row%0d core_rdata", row),  16'(bus.core_rdata),  16'(v.crd));
      chk($sformatf("row%0d host_rvalid", row), 16'(bus.host_rvalid), 16'(v.hrv));
      chk($sformatf("row%0d host_rdata", row),  16'(bus.host_rdata),  16'(v.hrd));
      chk($sformatf("row%0d stall_ct", row),    16'(stall_ct),        16'(v.sct));
      chk($sformatf("row%0d mem_en", row),      16'(bus.mem_en),      16'(v.cg | v.hg));
      row++;
      next_cycle();
    end

    // Async reset pulse right after a granted core read (wait_cnt at 2)
    drive(1,0,8'h10,8'h00, 1,0,0,8'h20,8'h00);
    next_cycle();
    drive(1,0,8'h10,8'h00, 1,0,0,8'h20,8'h00);
    #3;
    chk("pre-pulse core_gnt", 16'(bus.core_gnt), 16'd1);
    next_cycle();
    rst_n = 1'b0;
    #2;
    chk("pulse core_gnt", 16'(bus.core_gnt), 16'd0);
    chk("pulse host_gnt", 16'(bus.host_gnt), 16'd0);
    chk("pulse core_stall", 16'(bus.core_stall), 16'd0);
    chk("pulse core_rvalid", 16'(bus.core_rvalid), 16'd0);
    chk("pulse mem_en", 16'(bus.mem_en), 16'd0);
    chk("pulse mem_we", 16'(bus.mem_we), 16'd0);
    chk("pulse stall_ct", 16'(stall_ct), 16'd0);
    #2;
    rst_n = 1'b1;
    drive(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    #1;
    chk("release core_rvalid", 16'(bus.core_rvalid), 16'd0);
    next_cycle();
    #3;
    chk("post core_rvalid", 16'(bus.core_rvalid), 16'd0);
    chk("post host_rvalid", 16'(bus.host_rvalid), 16'd0);
    next_cycle();

    // wait_cnt restarts from 0: host must wait a full four cycles again
    for (int k = 0; k < 5; k++) begin
      drive(1,0,8'h10,8'h00, 1,1,0,8'h90,8'h22);
      #3;
      chk($sformatf("restart%0d core_gnt", k), 16'(bus.core_gnt), 16'(k != 4));
      chk($sformatf("restart%0d host_gnt", k), 16'(bus.host_gnt), 16'(k == 4));
      next_cycle();
    end

    // Saturation: host lock starves the core for 20 cycles
    drive(0,0,8'h00,8'h00, 1,1,1,8'hA0,8'h55);
    #3;
    chk("sat start host_gnt", 16'(bus.host_gnt), 16'd1);
    chk("sat start stall_ct", 16'(stall_ct), 16'd1);
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      drive(1,0,8'h10,8'h00, 1,1,1,8'hA0,8'h55);
      exp_ct = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
      #3;
      chk($sformatf("sat%0d host_gnt", k), 16'(bus.host_gnt), 16'd1);
      chk($sformatf("sat%0d core_stall", k), 16'(bus.core_stall), 16'd1);
      chk($sformatf("sat%0d stall_ct", k), 16'(stall_ct), 16'(exp_ct));
      next_cycle();
    end
    drive(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
    #3;
    chk("sat end stall_ct", 16'(stall_ct), 16'd15);
    next_cycle();
    drive(1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00);
    #3;
    chk("sat resume core_gnt", 16'(bus.core_gnt), 16'd1);
    chk("sat hold stall_ct", 16'(stall_ct), 16'd15);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
